// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_rx
//  Purpose  : WS2812 single-wire NRZ receiver. Oversamples din with clk,
//             classifies each high pulse as 0/1 by width, assembles 24-bit
//             GRB pixels MSB-first and flags the end of a frame when the
//             line stays low for the reset gap.
//  Ports    : clk          - system clock (50 MHz, 20 ns/tick)
//             rst_n        - asynchronous active-low reset
//             din          - WS2812 dataline, asynchronous to clk
//             pixel_data   - last decoded pixel {G,R,B}
//             pixel_valid  - one-cycle pulse when pixel_data updates
//             pixel_index  - 0-based index of pixel_data in the frame
//             frame_done   - one-cycle pulse at the reset gap after activity
//             frame_pixels - complete pixels in the last finished frame
//             err          - one-cycle pulse on timing violation/partial pixel
//  Revision : 1.0 - initial release
// ============================================================================
module ws2812_rx #(
   parameter int MIN_HIGH_TICKS = 8,
   parameter int BIT_THRESHOLD  = 30,
   parameter int MAX_HIGH_TICKS = 55,
   parameter int MAX_LOW_TICKS  = 250,
   parameter int RESET_TICKS    = 2500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din,
   output logic [23:0] pixel_data,
   output logic        pixel_valid,
   output logic [7:0]  pixel_index,
   output logic        frame_done,
   output logic [7:0]  frame_pixels,
   output logic        err
);

   localparam logic [15:0] MIN_T   = 16'(MIN_HIGH_TICKS);
   localparam logic [15:0] THR_T   = 16'(BIT_THRESHOLD);
   localparam logic [15:0] MAXH_T  = 16'(MAX_HIGH_TICKS);
   localparam logic [15:0] MAXL_T  = 16'(MAX_LOW_TICKS);
   localparam logic [15:0] RESET_T = 16'(RESET_TICKS);

   typedef enum logic [2:0] {
      ST_SYNC  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_GAP   = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   state_t      state;
   logic        sync1, din_s, din_d;
   logic [15:0] hi_cnt, lo_cnt;
   logic [23:0] shreg;
   logic [4:0]  bit_cnt;
   logic [7:0]  pix_cnt;
   logic        pend;

   logic rise, fall;
   assign rise = din_s & ~din_d;
   assign fall = ~din_s & din_d;

   // Synchronizer, edge history and phase-length counters. The counter of
   // the phase that just started restarts at 1 on its edge, so at the
   // following edge it holds the exact width of that phase in ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         din_s  <= 1'b0;
         din_d  <= 1'b0;
         hi_cnt <= 16'd0;
         lo_cnt <= 16'd0;
      end else begin
         sync1 <= din;
         din_s <= sync1;
         din_d <= din_s;
         if (rise)
            hi_cnt <= 16'd1;
         else if (din_s && hi_cnt != 16'hFFFF)
            hi_cnt <= hi_cnt + 16'd1;
         if (fall)
            lo_cnt <= 16'd1;
         else if (!din_s && lo_cnt != 16'hFFFF)
            lo_cnt <= lo_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_SYNC;
         shreg        <= 24'd0;
         bit_cnt      <= 5'd0;
         pix_cnt      <= 8'd0;
         pend         <= 1'b0;
         pixel_data   <= 24'd0;
         pixel_valid  <= 1'b0;
         pixel_index  <= 8'd0;
         frame_done   <= 1'b0;
         frame_pixels <= 8'd0;
         err          <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         err         <= 1'b0;

         // Publish a completed pixel the cycle after its 24th bit. The FSM
         // is always in LOW here, so nothing below touches pix_cnt.
         if (pend) begin
            pend        <= 1'b0;
            pixel_data  <= shreg;
            pixel_valid <= 1'b1;
            pixel_index <= pix_cnt;
            if (pix_cnt != 8'hFF)
               pix_cnt <= pix_cnt + 8'd1;
         end

         case (state)
            // Wait for a full reset gap so a mid-stream start never mis-frames.
            ST_SYNC: begin
               if (!din_s && lo_cnt >= RESET_T)
                  state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (rise)
                  state <= ST_HIGH;
            end
            ST_HIGH: begin
               if (fall) begin
                  if (hi_cnt < MIN_T || hi_cnt > MAXH_T) begin
                     err   <= 1'b1;
                     state <= ST_ERROR;
                  end else begin
                     shreg <= {shreg[22:0], (hi_cnt >= THR_T)};
                     if (bit_cnt == 5'd23) begin
                        bit_cnt <= 5'd0;
                        pend    <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                     state <= ST_LOW;
                  end
               end
            end
            ST_LOW: begin
               if (rise) begin
                  if (lo_cnt <= MAXL_T) begin
                     state <= ST_HIGH;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_ERROR;
                  end
               end else if (lo_cnt > MAXL_T) begin
                  // Too long for an inter-bit low: a partial pixel is dropped.
                  state <= ST_GAP;
                  if (bit_cnt != 5'd0) begin
                     err     <= 1'b1;
                     bit_cnt <= 5'd0;
                  end
               end
            end
            ST_GAP: begin
               if (rise) begin
                  err   <= 1'b1;
                  state <= ST_ERROR;
               end else if (lo_cnt >= RESET_T) begin
                  frame_done   <= 1'b1;
                  frame_pixels <= pix_cnt;
                  pix_cnt      <= 8'd0;
                  state        <= ST_IDLE;
               end
            end
            ST_ERROR: begin
               bit_cnt <= 5'd0;
               pix_cnt <= 8'd0;
               if (!din_s && lo_cnt >= RESET_T)
                  state <= ST_IDLE;
            end
            default: state <= ST_SYNC;
         endcase
      end
   end

endmodule
`default_nettype wire
